// File: rtl/nerv_uart_tx_if.sv
// NERV data-memory bus slice seen by a memory-mapped peripheral.
// The CPU/SoC fan-out drives the master side; peripherals take the slave side.
interface nerv_uart_tx_if;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_valid,
    output dmem_addr,
    output dmem_wstrb,
    output dmem_wdata,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_valid,
    input  dmem_addr,
    input  dmem_wstrb,
    input  dmem_wdata,
    output dmem_rdata
  );
endinterface

// File: rtl/nerv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a byte FIFO fed from the dmem bus,
// drained LSB-first onto tx by a baud-counted frame FSM.
module nerv_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd104
) (
  input  logic             clock,
  input  logic             reset,
  nerv_uart_tx_if.slave    bus,
  output logic             tx,
  output logic             irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Register state
  logic [31:0]      rdata_q;
  logic [15:0]      div_q;
  logic             irq_en_q;
  logic             ovf_q;
  logic             irq_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       fifo_mem [FIFO_DEPTH];

  // Frame FSM state
  state_t           state_q;
  logic [15:0]      cnt_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q;
  logic             tx_q;

  // Bus decode
  logic             hit, wr;
  logic [1:0]       sel;
  logic             push_req, push_ok, pop;
  logic             full, empty, busy, cnt_zero;
  logic [15:0]      div_d;
  logic [31:0]      reg_val;
  logic             unused_bits;

  assign hit      = bus.dmem_valid && (bus.dmem_addr[31:4] == BASE_ADDR[31:4]);
  assign sel      = bus.dmem_addr[3:2];
  assign wr       = hit && (bus.dmem_wstrb != 4'b0000);
  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign cnt_zero = (cnt_q == 16'd0);

  // The FSM takes a byte from IDLE, or at the end of STOP to chain frames.
  assign pop      = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && cnt_zero));
  assign push_req = wr && (sel == 2'd0) && bus.dmem_wstrb[0];
  assign push_ok  = push_req && (!full || pop);

  assign unused_bits = ^{bus.dmem_wdata[31:16], bus.dmem_addr[1:0]};

  always_comb begin
    div_d = div_q;
    if (bus.dmem_wstrb[0]) div_d[7:0]  = bus.dmem_wdata[7:0];
    if (bus.dmem_wstrb[1]) div_d[15:8] = bus.dmem_wdata[15:8];
    if (div_d == 16'd0) div_d = 16'd1;
  end

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    reg_val = 32'h0;
    case (sel)
      2'd1:    reg_val = {16'h0, 8'(level_q), 4'h0, ovf_q, busy, empty, full};
      2'd2:    reg_val = {16'h0, div_q};
      2'd3:    reg_val = {31'h0, irq_en_q};
      default: reg_val = 32'h0;
    endcase
  end

  // Storage array carries no reset so it can map onto RAM; pointers define validity.
  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= bus.dmem_wdata[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q  <= 32'h0;
      div_q    <= DIV_RESET;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (bus.dmem_valid) rdata_q <= hit ? reg_val : 32'h0;
      if (wr && sel == 2'd2) div_q <= div_d;
      if (wr && sel == 2'd3 && bus.dmem_wstrb[0]) irq_en_q <= bus.dmem_wdata[0];
      if (push_req && !push_ok)
        ovf_q <= 1'b1;
      else if (wr && sel == 2'd1 && bus.dmem_wstrb[0] && bus.dmem_wdata[3])
        ovf_q <= 1'b0;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      irq_q   <= irq_en_q && empty && (state_q == S_IDLE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      shift_q   <= 8'h0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= fifo_mem[rd_ptr_q];
            cnt_q   <= div_q - 16'd1;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_zero) begin
            cnt_q     <= div_q - 16'd1;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= 3'd0;
            state_q   <= S_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_zero) begin
            cnt_q <= div_q - 16'd1;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_zero) begin
            if (pop) begin
              shift_q <= fifo_mem[rd_ptr_q];
              cnt_q   <= div_q - 16'd1;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dmem_rdata = rdata_q;
  assign tx             = tx_q;
  assign irq            = irq_q;

endmodule
